// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 16x-oversampled 8N1 UART receiver with command decode.
// Turns the serial command stream into one-clock command strobes for the
// downstream vending-machine FSM.
module uart_cmd_rx #(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DIV      = CLK_FREQ / (BAUD * OVS)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic       cmd_one,
    output logic       cmd_five,
    output logic       cmd_ten,
    output logic       cmd_stop,
    output logic       cmd_reset,
    output logic       unknown_cmd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PH_W  = $clog2(OVS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [PH_W-1:0]  PH_MID   = PH_W'(OVS / 2 - 1);
    localparam logic [PH_W-1:0]  PH_END   = PH_W'(OVS - 1);

    localparam logic [7:0] CODE_ONE   = 8'h61;
    localparam logic [7:0] CODE_FIVE  = 8'h62;
    localparam logic [7:0] CODE_TEN   = 8'h63;
    localparam logic [7:0] CODE_STOP  = 8'h73;
    localparam logic [7:0] CODE_RESET = 8'h72;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic             sync1, rxs;
    logic [1:0]       settle;
    logic             armed;
    logic             tick;

    logic [2:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [PH_W-1:0]  ph, ph_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       data_nxt;
    logic             one_nxt, five_nxt, ten_nxt, stop_nxt, rst_cmd_nxt;
    logic             unk_nxt, valid_nxt, ferr_nxt;

    assign tick = (cnt == CNT_LAST);

    // Two-flop synchroniser; a start is only accepted once a genuine idle-high
    // level has been seen after reset, so a line that is low at reset release
    // (e.g. mid-frame) cannot fake a start edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b1;
            rxs    <= 1'b1;
            settle <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sync1  <= RxD;
            rxs    <= sync1;
            settle <= {settle[0], 1'b1};
            armed  <= armed | (settle[1] & rxs);
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ph          <= '0;
            idx         <= '0;
            shreg       <= '0;
            rx_data     <= '0;
            cmd_one     <= 1'b0;
            cmd_five    <= 1'b0;
            cmd_ten     <= 1'b0;
            cmd_stop    <= 1'b0;
            cmd_reset   <= 1'b0;
            unknown_cmd <= 1'b0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            ph          <= ph_nxt;
            idx         <= idx_nxt;
            shreg       <= shreg_nxt;
            rx_data     <= data_nxt;
            cmd_one     <= one_nxt;
            cmd_five    <= five_nxt;
            cmd_ten     <= ten_nxt;
            cmd_stop    <= stop_nxt;
            cmd_reset   <= rst_cmd_nxt;
            unknown_cmd <= unk_nxt;
            rx_valid    <= valid_nxt;
            frame_err   <= ferr_nxt;
        end
    end

    // Next-state, sampling and decode logic.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = tick ? '0 : cnt + CNT_W'(1);
        ph_nxt      = tick ? ph + PH_W'(1) : ph;
        idx_nxt     = idx;
        shreg_nxt   = shreg;
        data_nxt    = rx_data;
        one_nxt     = 1'b0;
        five_nxt    = 1'b0;
        ten_nxt     = 1'b0;
        stop_nxt    = 1'b0;
        rst_cmd_nxt = 1'b0;
        unk_nxt     = 1'b0;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                // Holding the counters at zero aligns sampling to the start edge.
                cnt_nxt = '0;
                ph_nxt  = '0;
                idx_nxt = '0;
                if (armed && !rxs) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (tick && ph == PH_MID) begin
                    if (rxs) begin
                        state_nxt = S_IDLE;
                    end else begin
                        ph_nxt    = '0;
                        idx_nxt   = '0;
                        state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (tick && ph == PH_END) begin
                    shreg_nxt = {rxs, shreg[7:1]};
                    if (idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        idx_nxt = idx + 3'd1;
                    end
                end
            end
            S_STOP: begin
                // Leaving at mid stop bit lets a back-to-back start bit be caught.
                if (tick && ph == PH_END) begin
                    if (rxs) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                        state_nxt = S_IDLE;
                        case (shreg)
                            CODE_ONE:   one_nxt     = 1'b1;
                            CODE_FIVE:  five_nxt    = 1'b1;
                            CODE_TEN:   ten_nxt     = 1'b1;
                            CODE_STOP:  stop_nxt    = 1'b1;
                            CODE_RESET: rst_cmd_nxt = 1'b1;
                            default:    unk_nxt     = 1'b1;
                        endcase
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (rxs) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
